// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback types (entry layout, source ids) and the default data width
package wb_pkg;
  localparam int DATA_W = 64;
  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
  typedef enum logic [1:0] {SRC_ALU, SRC_LSU, SRC_NPU, SRC_NONE} wb_src_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: producer valid/ready/rd/data channels (alu, lsu, npu), regfile write ports a/b, wb_idle; master = arbiter side, slave = producers/regfile side
interface wb_arbiter_if #(parameter int DATA_W = wb_pkg::DATA_W);
  logic              alu_valid, lsu_valid, npu_valid;
  logic              alu_ready, lsu_ready, npu_ready;
  logic [4:0]        alu_rd, lsu_rd, npu_rd;
  logic [DATA_W-1:0] alu_data, lsu_data, npu_data;
  logic              write_enable_a, write_enable_b;
  logic [4:0]        write_addr_a, write_addr_b;
  logic [DATA_W-1:0] write_data_a, write_data_b;
  logic              wb_idle;
  modport master (
    input  alu_valid, lsu_valid, npu_valid, alu_rd, lsu_rd, npu_rd, alu_data, lsu_data, npu_data,
    output alu_ready, lsu_ready, npu_ready, write_enable_a, write_enable_b,
    output write_addr_a, write_addr_b, write_data_a, write_data_b, wb_idle
  );
  modport slave (
    output alu_valid, lsu_valid, npu_valid, alu_rd, lsu_rd, npu_rd, alu_data, lsu_data, npu_data,
    input  alu_ready, lsu_ready, npu_ready, write_enable_a, write_enable_b,
    input  write_addr_a, write_addr_b, write_data_a, write_data_b, wb_idle
  );
endinterface

// File: rtl/wb_fifo2.sv
// wb_fifo2: 2-entry FIFO; ports clk, rst_n, push_valid/push_data (accepted when !full), pop, head, full, empty
module wb_fifo2 #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  logic [1:0]   cnt;
  logic [W-1:0] tail;
  logic         push, pp;
  assign full  = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign push  = push_valid & ~full;
  assign pp    = pop & ~empty;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 2'd0;
    else cnt <= cnt + {1'b0, push} - {1'b0, pp};
  always_ff @(posedge clk) begin
    if (pp) head <= full ? tail : push_data;
    else if (push && empty) head <= push_data;
    if (push && cnt == 2'd1 && !pp) tail <= push_data;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: three-source writeback arbiter onto dual regfile write ports; ports clk, rst_n (async active-low), bus (wb_arbiter_if.master)
module wb_arbiter #(
  parameter int DATA_W       = wb_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter_if.master  bus
);
  import wb_pkg::*;
  localparam int EW = DATA_W + 5;
  logic [2:0]        in_v, full, empty, pop, act, x0, starved, gnt;
  logic [EW-1:0]     in_e [3];
  logic [EW-1:0]     hd [3];
  logic [4:0]        hrd [3];
  logic [DATA_W-1:0] hdat [3];
  logic [7:0]        wcnt [3];
  wb_src_e           ga, gb;
  logic [4:0]        rd_a, rd_b, addr_a, addr_b;
  logic [DATA_W-1:0] d_a, d_b, data_a, data_b;
  logic              we_a, we_b;
  assign in_v  = {bus.npu_valid, bus.lsu_valid, bus.alu_valid};
  assign in_e[0] = {bus.alu_rd, bus.alu_data};
  assign in_e[1] = {bus.lsu_rd, bus.lsu_data};
  assign in_e[2] = {bus.npu_rd, bus.npu_data};
  for (genvar i = 0; i < 3; i++) begin : g_src
    wb_fifo2 #(.W(EW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_valid(in_v[i]),
      .push_data (in_e[i]),
      .pop       (pop[i]),
      .head      (hd[i]),
      .full      (full[i]),
      .empty     (empty[i])
    );
    assign hrd[i]     = hd[i][EW-1 -: 5];
    assign hdat[i]    = hd[i][DATA_W-1:0];
    assign x0[i]      = ~empty[i] && hrd[i] == 5'd0;
    assign act[i]     = ~empty[i] && hrd[i] != 5'd0;
    assign starved[i] = wcnt[i] == 8'(STARVE_LIMIT);
    assign pop[i]     = gnt[i] | x0[i];
  end
  always_comb begin
    ga   = SRC_NONE;
    gb   = SRC_NONE;
    gnt  = '0;
    rd_a = '0;
    rd_b = '0;
    d_a  = '0;
    d_b  = '0;
    for (int p = 0; p < 6; p++)
      if (act[p % 3] && starved[p % 3] == (p < 3)) begin
        if (ga == SRC_NONE) begin
          ga = wb_src_e'(2'(p % 3));
          rd_a = hrd[p % 3];
          d_a = hdat[p % 3];
          gnt[p % 3] = 1'b1;
        end else if (gb == SRC_NONE && hrd[p % 3] != rd_a) begin
          gb = wb_src_e'(2'(p % 3));
          rd_b = hrd[p % 3];
          d_b = hdat[p % 3];
          gnt[p % 3] = 1'b1;
        end
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 3; i++) wcnt[i] <= '0;
    else for (int i = 0; i < 3; i++) wcnt[i] <= (!act[i] || gnt[i]) ? '0 : starved[i] ? wcnt[i] : wcnt[i] + 8'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_a   <= 1'b0;
      we_b   <= 1'b0;
      addr_a <= '0;
      addr_b <= '0;
      data_a <= '0;
      data_b <= '0;
    end else begin
      we_a <= ga != SRC_NONE;
      we_b <= gb != SRC_NONE;
      if (ga != SRC_NONE) {addr_a, data_a} <= {rd_a, d_a};
      if (gb != SRC_NONE) {addr_b, data_b} <= {rd_b, d_b};
    end
  assign bus.alu_ready      = rst_n & ~full[0];
  assign bus.lsu_ready      = rst_n & ~full[1];
  assign bus.npu_ready      = rst_n & ~full[2];
  assign bus.write_enable_a = we_a;
  assign bus.write_enable_b = we_b;
  assign bus.write_addr_a   = addr_a;
  assign bus.write_addr_b   = addr_b;
  assign bus.write_data_a   = data_a;
  assign bus.write_data_b   = data_b;
  assign bus.wb_idle        = &empty & ~we_a & ~we_b;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scoreboard bench for wb_arbiter; expected writes queued per port, checked by a monitor
module tb_wb_arbiter;
  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  wb_arbiter_if #(.DATA_W(64)) bus();
  wb_arbiter #(.DATA_W(64), .STARVE_LIMIT(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic expect_w(input bit b, input int c, input logic [4:0] rd, input logic [63:0] d);
    exp_t e;
    e.cyc = c;
    e.rd = rd;
    e.data = d;
    if (b) qb.push_back(e);
    else qa.push_back(e);
  endtask
  task automatic src(input logic [2:0] v, input logic [4:0] ar, input logic [63:0] ad,
                     input logic [4:0] lr, input logic [63:0] ld, input logic [4:0] nr, input logic [63:0] nd);
    bus.alu_valid = v[0];
    bus.lsu_valid = v[1];
    bus.npu_valid = v[2];
    bus.alu_rd = ar;
    bus.alu_data = ad;
    bus.lsu_rd = lr;
    bus.lsu_data = ld;
    bus.npu_rd = nr;
    bus.npu_data = nd;
  endtask
  task automatic mon_port(input string nm, input logic we, input logic [4:0] ad, input logic [63:0] d, ref exp_t q[$]);
    exp_t e;
    if (we) begin
      checks++;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        if (ad !== e.rd || d !== e.data) begin
          errors++;
          $display("FAIL %s cycle %0d got x%0d=%h want x%0d=%h", nm, cyc, ad, d, e.rd, e.data);
        end
      end else begin
        errors++;
        $display("FAIL %s unexpected write x%0d=%h at cycle %0d", nm, ad, d, cyc);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing write got none want x%0d=%h at cycle %0d", nm, e.rd, e.data, e.cyc);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    mon_port("port_a", bus.write_enable_a, bus.write_addr_a, bus.write_data_a, qa);
    mon_port("port_b", bus.write_enable_b, bus.write_addr_b, bus.write_data_b, qb);
    if (bus.write_enable_a && bus.write_enable_b)
      chk("port_addr_clash", 64'(bus.write_addr_a == bus.write_addr_b), 64'd0);
  end
  initial begin
    int c;
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_we", {bus.write_enable_b, bus.write_enable_a}, 64'd0);
    chk("rst_addr", {bus.write_addr_b, bus.write_addr_a}, 64'd0);
    chk("rst_data_a", bus.write_data_a, 64'd0);
    chk("rst_data_b", bus.write_data_b, 64'd0);
    chk("rst_ready", {bus.npu_ready, bus.lsu_ready, bus.alu_ready}, 64'd0);
    chk("rst_idle", bus.wb_idle, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {bus.npu_ready, bus.lsu_ready, bus.alu_ready}, 64'd7);
    c = cyc;
    expect_w(0, c + 2, 5'd5, 64'h1234);
    src(3'b001, 5'd5, 64'h1234, 5'd0, 64'd0, 5'd0, 64'd0);
    @(negedge clk);
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    repeat (4) @(negedge clk);
    c = cyc;
    expect_w(0, c + 2, 5'd3, 64'h33);
    expect_w(1, c + 2, 5'd7, 64'h77);
    src(3'b101, 5'd3, 64'h33, 5'd0, 64'd0, 5'd7, 64'h77);
    @(negedge clk);
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    repeat (4) @(negedge clk);
    c = cyc;
    expect_w(0, c + 2, 5'd9, 64'hAA);
    expect_w(0, c + 3, 5'd9, 64'hBB);
    src(3'b110, 5'd0, 64'd0, 5'd9, 64'hAA, 5'd9, 64'hBB);
    @(negedge clk);
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    repeat (5) @(negedge clk);
    src(3'b100, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'hDEAD);
    @(negedge clk);
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    chk("x0_busy", bus.wb_idle, 64'd0);
    @(negedge clk);
    chk("x0_idle", bus.wb_idle, 64'd1);
    repeat (3) @(negedge clk);
    c = cyc;
    for (int g = 1; g <= 8; g++) begin
      expect_w(0, c + g + 1, 5'd10, 64'hA000 + 64'(g - 1));
      expect_w(1, c + g + 1, 5'd11, 64'hB000 + 64'(g - 1));
    end
    expect_w(0, c + 10, 5'd20, 64'h5A5A);
    expect_w(1, c + 10, 5'd10, 64'hA008);
    expect_w(0, c + 11, 5'd10, 64'hA009);
    expect_w(1, c + 11, 5'd11, 64'hB008);
    expect_w(0, c + 12, 5'd11, 64'hB009);
    for (int k = 0; k < 10; k++) begin
      src({k == 0, 2'b11}, 5'd10, 64'hA000 + 64'(k), 5'd11, 64'hB000 + 64'(k), 5'd20, 64'h5A5A);
      @(negedge clk);
    end
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    chk("starve_lsu_full", bus.lsu_ready, 64'd0);
    repeat (6) @(negedge clk);
    chk("starve_drained", bus.wb_idle, 64'd1);
    c = cyc;
    expect_w(0, c + 2, 5'd4, 64'hC000);
    src(3'b011, 5'd4, 64'hC000, 5'd4, 64'hD000, 5'd0, 64'd0);
    @(negedge clk);
    src(3'b011, 5'd4, 64'hC001, 5'd4, 64'hD001, 5'd0, 64'd0);
    @(negedge clk);
    src(3'b000, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 64'd0);
    chk("bp_lsu_ready", bus.lsu_ready, 64'd0);
    chk("bp_we_a_live", bus.write_enable_a, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", {bus.write_enable_b, bus.write_enable_a}, 64'd0);
    chk("async_rst_ready", {bus.npu_ready, bus.lsu_ready, bus.alu_ready}, 64'd0);
    chk("async_rst_idle", bus.wb_idle, 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus.wb_idle, 64'd1);
    chk("post_rst_ready", {bus.npu_ready, bus.lsu_ready, bus.alu_ready}, 64'd7);
    chk("post_rst_addr_a", bus.write_addr_a, 64'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_still_idle", bus.wb_idle, 64'd1);
    chk("queue_a_drained", 64'(qa.size()), 64'd0);
    chk("queue_b_drained", 64'(qb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
